// File: rtl/program_memory_loader_pkg.sv
// Shared types and constants for the Jimmy CPU program store.
// Holds the CPU opcode constants and the loader FSM state encoding.
package program_memory_loader_pkg;

    localparam logic [7:0] OP_NOP           = 8'h70;
    localparam logic [7:0] OP_BRA           = 8'h9D;
    localparam logic [7:0] NOP_WORD_DEFAULT = OP_NOP;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/program_memory_loader.sv
// Writable program store for the Jimmy CPU: NOP-filled after reset, loaded at run time
// from a byte stream, and holds the CPU on NOPs while clearing or loading.
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                  program_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_bus,
    output logic [DATA_WIDTH-1:0] data_bus,
    output logic                  cpu_hold,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic [DATA_WIDTH-1:0] load_checksum
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_cpu_hold;
    logic                  r_load_ready;
    logic                  r_load_done;
    logic                  r_load_overflow;
    logic [DATA_WIDTH-1:0] r_load_checksum;

    state_e                w_next_state;
    logic [ADDR_WIDTH-1:0] w_next_ptr;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_done;
    logic                  w_next_overflow;
    logic [DATA_WIDTH-1:0] w_next_checksum;

    // Next-state, pointer, write-port and load status logic
    always_comb begin
        w_next_state    = r_state;
        w_next_ptr      = r_ptr;
        w_mem_we        = 1'b0;
        w_mem_wdata     = NOP_WORD;
        w_done          = 1'b0;
        w_next_overflow = r_load_overflow;
        w_next_checksum = r_load_checksum;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we = 1'b1;
                if (r_ptr == LAST_ADDR) begin
                    w_next_state = ST_RUN;
                    w_next_ptr   = PTR_ZERO;
                end else begin
                    w_next_ptr = r_ptr + PTR_ONE;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    w_next_state    = ST_LOAD;
                    w_next_ptr      = PTR_ZERO;
                    w_next_checksum = '0;
                    w_next_overflow = 1'b0;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_LOAD: begin
                // load_ready is always 1 in LOAD, so a beat is just load_valid
                if (load_valid) begin
                    w_mem_we        = 1'b1;
                    w_mem_wdata     = load_data;
                    w_next_checksum = r_load_checksum + load_data;
                    if (load_last) begin
                        w_next_state = ST_RUN;
                        w_next_ptr   = PTR_ZERO;
                        w_done       = 1'b1;
                    end else if (r_ptr == LAST_ADDR) begin
                        w_next_state    = ST_RUN;
                        w_next_ptr      = PTR_ZERO;
                        w_done          = 1'b1;
                        w_next_overflow = 1'b1;
                    end else begin
                        w_next_ptr = r_ptr + PTR_ONE;
                    end
                end else begin
                    w_next_ptr = r_ptr;
                end
            end
            default: begin
                w_next_state = ST_CLEAR;
                w_next_ptr   = PTR_ZERO;
            end
        endcase
    end

    // State, pointer and registered status outputs
    always_ff @(posedge program_clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_CLEAR;
            r_ptr           <= PTR_ZERO;
            r_cpu_hold      <= 1'b1;
            r_load_ready    <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
            r_load_checksum <= '0;
        end else begin
            r_state         <= w_next_state;
            r_ptr           <= w_next_ptr;
            r_cpu_hold      <= (w_next_state != ST_RUN);
            r_load_ready    <= (w_next_state == ST_LOAD);
            r_load_done     <= w_done;
            r_load_overflow <= w_next_overflow;
            r_load_checksum <= w_next_checksum;
        end
    end

    // Program array write port; contents deliberately survive reset until CLEAR overwrites them
    always_ff @(posedge program_clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_mem_wdata;
        end
    end

    assign data_bus      = r_cpu_hold ? NOP_WORD : r_mem[address_bus];
    assign cpu_hold      = r_cpu_hold;
    assign load_ready    = r_load_ready;
    assign load_done     = r_load_done;
    assign load_overflow = r_load_overflow;
    assign load_checksum = r_load_checksum;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader with a 16-word array: directed loads,
// stalls, overflow, reset mid-load and ignored load_start pulses.
module tb_program_memory_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_bus = '0;
    logic [DW-1:0] data_bus;
    logic          cpu_hold;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic [DW-1:0] load_checksum;

    int checks = 0;
    int errors = 0;

    logic [8:0]    done_q [$];
    logic [DW-1:0] rd_q [$];
    logic          rd_strobe = 1'b0;
    logic [8:0]    mon_done_exp;
    logic [DW-1:0] mon_rd_exp;

    logic [DW-1:0] fact_img [15] = '{8'h10, 8'h01, 8'h20, 8'h05, 8'h31, 8'h00, 8'h42, 8'h01,
                                     8'h53, 8'h02, 8'h64, 8'h0A, 8'h9D, 8'h03, 8'h70};
    logic [DW-1:0] small_img [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    program_memory_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NOP_WORD   (8'h70)
    ) dut (
        .program_clk   (clk),
        .reset         (reset),
        .address_bus   (address_bus),
        .data_bus      (data_bus),
        .cpu_hold      (cpu_hold),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_checksum (load_checksum)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expected completion status on load_done and expected read data on rd_strobe
    always @(negedge clk) begin
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_done_exp = done_q.pop_front();
                chk("done_overflow", {31'd0, load_overflow}, {23'd0, mon_done_exp[8]});
                chk("done_checksum", {24'd0, load_checksum}, {24'd0, mon_done_exp[7:0]});
            end
        end
        if (rd_strobe) begin
            if (rd_q.size() != 0) begin
                mon_rd_exp = rd_q.pop_front();
                chk("read_data", {24'd0, data_bus}, {24'd0, mon_rd_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        address_bus = addr;
        rd_q.push_back(exp);
        rd_strobe = 1'b1;
        @(negedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Follows CLEAR after reset release; optionally pokes load_start during it
    task automatic clear_check(input bit poke);
        for (int i = 0; i < DEPTH; i++) begin
            chk("clear_hold", {31'd0, cpu_hold}, 32'd1);
            chk("clear_data", {24'd0, data_bus}, 32'h70);
            chk("clear_ready", {31'd0, load_ready}, 32'd0);
            load_start = (poke && (i == 3));
            tick();
            load_start = 1'b0;
        end
        chk("run_hold", {31'd0, cpu_hold}, 32'd0);
        chk("run_ready", {31'd0, load_ready}, 32'd0);
    endtask

    initial begin
        address_bus = 4'd5;
        tick();
        tick();
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_overflow", {31'd0, load_overflow}, 32'd0);
        chk("rst_checksum", {24'd0, load_checksum}, 32'd0);
        chk("rst_data", {24'd0, data_bus}, 32'h70);
        reset = 1'b1;

        // Power-up NOP fill
        clear_check(1'b0);
        chk("run_data_a5", {24'd0, data_bus}, 32'h70);

        // Factorial image, 15 words, checksum 0x7D
        start_load();
        chk("load_hold", {31'd0, cpu_hold}, 32'd1);
        chk("load_ready", {31'd0, load_ready}, 32'd1);
        chk("load_data_held", {24'd0, data_bus}, 32'h70);
        done_q.push_back({1'b0, 8'h7D});
        for (int i = 0; i < 15; i++) beat(fact_img[i], (i == 14));
        chk("fact_hold", {31'd0, cpu_hold}, 32'd0);
        chk("fact_ready", {31'd0, load_ready}, 32'd0);
        read_check(4'd12, 8'h9D);
        read_check(4'd0, 8'h10);
        read_check(4'd14, 8'h70);
        read_check(4'd15, 8'h70);

        // Stalled stream with a stray load_start mid-load; checksum 0xEA
        start_load();
        done_q.push_back({1'b0, 8'hEA});
        beat(small_img[0], 1'b0);
        beat(small_img[1], 1'b0);
        for (int g = 0; g < 3; g++) begin
            load_data  = 8'hFF;
            load_start = (g == 0);
            tick();
            load_start = 1'b0;
            chk("gap_checksum", {24'd0, load_checksum}, 32'h53);
            chk("gap_ready", {31'd0, load_ready}, 32'd1);
        end
        beat(small_img[2], 1'b0);
        beat(small_img[3], 1'b1);
        read_check(4'd0, 8'hA1);
        read_check(4'd1, 8'hB2);
        read_check(4'd2, 8'hC3);
        read_check(4'd3, 8'hD4);
        read_check(4'd4, 8'h31);
        read_check(4'd12, 8'h9D);

        // Overflow: 17 words, no last; 16 accepted, checksum 0x78
        start_load();
        done_q.push_back({1'b1, 8'h78});
        for (int i = 0; i < 17; i++) begin
            chk("ovf_ready", {31'd0, load_ready}, (i < 16) ? 32'd1 : 32'd0);
            beat(8'h20 + 8'(i), 1'b0);
        end
        tick();
        chk("ovf_sticky", {31'd0, load_overflow}, 32'd1);
        read_check(4'd0, 8'h20);
        read_check(4'd15, 8'h2F);

        // 16 words with last on the final address: normal completion, checksum 0x88
        start_load();
        chk("ovf_cleared", {31'd0, load_overflow}, 32'd0);
        done_q.push_back({1'b0, 8'h88});
        for (int i = 0; i < 16; i++) beat(8'(i + 1), (i == 15));
        chk("full_overflow", {31'd0, load_overflow}, 32'd0);
        read_check(4'd15, 8'h10);

        // Reset during a load, then refill with a load_start poked during CLEAR
        start_load();
        for (int i = 0; i < 6; i++) beat(8'h55, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'h55;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_mid_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_mid_overflow", {31'd0, load_overflow}, 32'd0);
        chk("rst_mid_checksum", {24'd0, load_checksum}, 32'd0);
        load_valid = 1'b0;
        tick();
        reset = 1'b1;
        clear_check(1'b1);
        for (int a = 0; a < DEPTH; a++) read_check(AW'(a), 8'h70);

        tick();
        chk("done_q_empty", done_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
